sevenseg_to_binary_decoder: RTL and testbench

//  Loopback decoder for the triple seven-segment display path. Captures three

---
 rtl/sevenseg_to_binary_decoder.sv | 128 ++++++++++++
 tb/tb_sevenseg_to_binary_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_to_binary_decoder.sv
// Decodes a captured triple of active-low 7-segment codes (huns/tens/ones) into a binary count.
// Optional build macro: DECODE_LEADING_BLANK_EN (all-off code in huns/tens reads as a blanked zero).
module sevenseg_to_binary_decoder #(
  parameter int OUT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           huns,
  input  logic [6:0]           tens,
  input  logic [6:0]           ones,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] value,
  output logic                 digit_err
);

  typedef enum logic [2:0] {S_IDLE, S_HUNS, S_TENS, S_ONES, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [6:0]             huns_q, tens_q, ones_q, cur_code;
  logic [OUT_WIDTH-1:0]   acc_q, acc_d, value_q;
  logic                   err_q, err_d, digit_err_q, out_valid_q;
  logic                   blank_ok;
  logic [4:0]             dec;

  // Returns {invalid, digit}; invalid codes read as digit 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] code, input logic blank);
    logic [4:0] res;
    case (code)
      7'b1000000: res = 5'd0;
      7'b1111001: res = 5'd1;
      7'b0100100: res = 5'd2;
      7'b0110000: res = 5'd3;
      7'b0011001: res = 5'd4;
      7'b0010010: res = 5'd5;
      7'b0000010: res = 5'd6;
      7'b1111000: res = 5'd7;
      7'b0000000: res = 5'd8;
      7'b0011000: res = 5'd9;
      7'b1111111: res = blank ? 5'b0_0000 : 5'b1_0000;
      default:    res = 5'b1_0000;
    endcase
    return res;
  endfunction

  always_comb begin
    cur_code = ones_q;
    if (state_q == S_HUNS)      cur_code = huns_q;
    else if (state_q == S_TENS) cur_code = tens_q;
`ifdef DECODE_LEADING_BLANK_EN
    blank_ok = (state_q == S_HUNS) || (state_q == S_TENS);
`else
    blank_ok = 1'b0;
`endif
    dec   = seg_decode(cur_code, blank_ok);
    acc_d = (acc_q << 3) + (acc_q << 1) + OUT_WIDTH'(dec[3:0]);
    err_d = err_q | dec[4];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_HUNS;
      S_HUNS:  state_d = S_TENS;
      S_TENS:  state_d = S_ONES;
      S_ONES:  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE) && !rst;
  end

  // Datapath: capture in IDLE, one digit per cycle, publish on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      huns_q      <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      value_q     <= '0;
      digit_err_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            huns_q <= huns;
            tens_q <= tens;
            ones_q <= ones;
            acc_q  <= '0;
            err_q  <= 1'b0;
          end
        end
        S_HUNS, S_TENS: begin
          acc_q <= acc_d;
          err_q <= err_d;
        end
        S_ONES: begin
          acc_q       <= acc_d;
          err_q       <= err_d;
          value_q     <= acc_d;
          digit_err_q <= err_d;
          out_valid_q <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign value     = value_q;
  assign digit_err = digit_err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sevenseg_to_binary_decoder.sv
// Scoreboard bench for sevenseg_to_binary_decoder: expected results are queued at capture, compared at handshake.
module tb_sevenseg_to_binary_decoder;

  localparam int OUT_WIDTH = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [6:0]           huns = '0, tens = '0, ones = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [OUT_WIDTH-1:0] value;
  logic                 digit_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   val;
    logic err;
  } exp_t;
  exp_t sb_q[$];

  logic [6:0] SEG [10];
  initial begin
    SEG[0] = 7'b1000000; SEG[1] = 7'b1111001; SEG[2] = 7'b0100100; SEG[3] = 7'b0110000;
    SEG[4] = 7'b0011001; SEG[5] = 7'b0010010; SEG[6] = 7'b0000010; SEG[7] = 7'b1111000;
    SEG[8] = 7'b0000000; SEG[9] = 7'b0011000;
  end

  sevenseg_to_binary_decoder #(.OUT_WIDTH(OUT_WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .huns(huns), .tens(tens), .ones(ones),
    .out_valid(out_valid), .out_ready(out_ready),
    .value(value), .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference decode: returns {invalid, digit}; pos 0=huns, 1=tens, 2=ones.
  function automatic logic [4:0] ref_dec(input logic [6:0] code, input int pos);
    logic [4:0] r;
    r = 5'b1_0000;
    for (int i = 0; i < 10; i++) if (code == SEG[i]) r = 5'(i);
`ifdef DECODE_LEADING_BLANK_EN
    if (code == 7'b1111111 && pos < 2) r = 5'd0;
`else
    if (pos < 0) r = 5'd0;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives one triple; optionally queues the expected result at the capture edge.
  task automatic send(input logic [6:0] h, input logic [6:0] t, input logic [6:0] o, input bit push);
    int n;
    logic [4:0] dh, dt, dn;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    huns = h; tens = t; ones = o; in_valid = 1'b1;
    @(posedge clk);
    dh = ref_dec(h, 0); dt = ref_dec(t, 1); dn = ref_dec(o, 2);
    e.val = int'(dh[3:0]) * 100 + int'(dt[3:0]) * 10 + int'(dn[3:0]);
    e.err = dh[4] | dt[4] | dn[4];
    if (push) sb_q.push_back(e);
    #1;
    in_valid = 1'b0;
    huns = 7'h55; tens = 7'h2A; ones = 7'h33;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !in_ready) && n < 60) begin tick(); n++; end
    chk("drain", 32'(sb_q.size()), 0);
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready && !rst) begin
      if (sb_q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("value", 32'(value), 32'(e.val));
        chk("digit_err", 32'(digit_err), 32'(e.err));
      end
    end
  end

  initial begin
    int n, cnt;
    logic [6:0] h, t, o;
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    tick();
    rst = 1'b0;
    #0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_value", 32'(value), 0);
    chk("rst_digit_err", 32'(digit_err), 0);
    chk("rst_release_in_ready", 32'(in_ready), 1);

    // 123, latency counted in edges including the capture edge
    send(SEG[1], SEG[2], SEG[3], 1);
    n = 1;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("latency", 32'(n), 4);
    chk("busy_in_ready", 32'(in_ready), 0);
    drain();

    send(SEG[9], SEG[9], SEG[9], 1);
    send(SEG[0], SEG[0], SEG[0], 1);
    send(SEG[1], SEG[2], 7'b1110001, 1);
    send(SEG[0], SEG[0], SEG[5], 1);
    drain();

    // Back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    send(SEG[2], SEG[5], SEG[5], 1);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 6; i++) begin
      chk("hold_value", 32'(value), 255);
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("release_out_valid", 32'(out_valid), 0);
    chk("release_in_ready", 32'(in_ready), 1);
    chk("keep_value", 32'(value), 255);
    drain();

    // Abort mid-conversion
    send(SEG[3], SEG[4], SEG[5], 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #0;
    chk("abort_in_ready", 32'(in_ready), 1);
    chk("abort_value", 32'(value), 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) cnt++;
      tick();
    end
    chk("abort_no_valid", 32'(cnt), 0);

    send(7'b1111111, SEG[1], SEG[2], 1);
    drain();
    send(SEG[4], 7'b1111111, SEG[7], 1);
    send(SEG[6], SEG[8], 7'b1111111, 1);
    drain();

    // Random triples, mixing valid and arbitrary codes
    for (int k = 0; k < 25; k++) begin
      h = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SEG[$urandom_range(0, 9)];
      t = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SEG[$urandom_range(0, 9)];
      o = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SEG[$urandom_range(0, 9)];
      send(h, t, o, 1);
    end
    drain();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
